// File: rtl/uart_tx_demo_unit.sv
// uart_tx_demo_unit
// Self-running UART transmit demonstrator. Repeatedly sends "HELLO\r\n" as
// 8N1 frames, with a quiet gap of GAP_CYCLES clocks between messages.
//
// Parameters:
//   CLKS_PER_BIT - clock cycles per UART bit (139 = 16 MHz / 115200)
//   GAP_CYCLES   - idle cycles between messages (>= 1)
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous reset, ACTIVE HIGH (the name is historical)
//   led   - toggles once per completed message
//   idle  - 1 while the transmitter is idle, 0 throughout a message
//   tx    - UART serial output, idle high
module uart_tx_demo_unit #(
    parameter int CLKS_PER_BIT = 139,
    parameter int GAP_CYCLES   = 16000000
) (
    input  logic clk,
    input  logic rst_n,
    output logic led,
    output logic idle,
    output logic tx
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
    localparam logic [2:0]    LAST_BYTE = 3'd6;

    // Message bytes packed with byte 0 in the low lane; lane 7 is unused padding
    // so the ROM can be indexed by the full 3-bit byte index.
    localparam logic [63:0] MSG = {8'h00, 8'h0A, 8'h0D, 8'h4F,
                                   8'h4C, 8'h4C, 8'h45, 8'h48};

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic {SEQ_SEND, SEQ_GAP} seq_state_t;

    logic [7:0] rom [0:7];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rom
            assign rom[gi] = MSG[gi*8 +: 8];
        end
    endgenerate

    tx_state_t       tx_state_reg, tx_state_next;
    seq_state_t      seq_state_reg, seq_state_next;
    logic [BW-1:0]   baud_cnt_reg, baud_cnt_next;
    logic [2:0]      bit_idx_reg, bit_idx_next;
    logic [2:0]      byte_idx_reg, byte_idx_next;
    logic [GW-1:0]   gap_cnt_reg, gap_cnt_next;
    logic            led_reg, led_next;
    logic            tx_reg, tx_next;
    logic            idle_reg, idle_next;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            tx_state_reg  <= TX_IDLE;
            seq_state_reg <= SEQ_SEND;
            baud_cnt_reg  <= '0;
            bit_idx_reg   <= '0;
            byte_idx_reg  <= '0;
            gap_cnt_reg   <= '0;
            led_reg       <= 1'b0;
            tx_reg        <= 1'b1;
            idle_reg      <= 1'b1;
        end else begin
            tx_state_reg  <= tx_state_next;
            seq_state_reg <= seq_state_next;
            baud_cnt_reg  <= baud_cnt_next;
            bit_idx_reg   <= bit_idx_next;
            byte_idx_reg  <= byte_idx_next;
            gap_cnt_reg   <= gap_cnt_next;
            led_reg       <= led_next;
            tx_reg        <= tx_next;
            idle_reg      <= idle_next;
        end
    end

    always_comb begin
        tx_state_next  = tx_state_reg;
        seq_state_next = seq_state_reg;
        baud_cnt_next  = baud_cnt_reg;
        bit_idx_next   = bit_idx_reg;
        byte_idx_next  = byte_idx_reg;
        gap_cnt_next   = gap_cnt_reg;
        led_next       = led_reg;

        case (tx_state_reg)
            TX_IDLE: begin
                // SEND while idle only occurs right after reset: start at once.
                // In GAP the start bit is launched on the edge the gap expires,
                // so the start edge lands exactly GAP_CYCLES after idle rose.
                if (seq_state_reg == SEQ_SEND) begin
                    tx_state_next = TX_START;
                    baud_cnt_next = '0;
                end else if (gap_cnt_reg == GAP_LAST) begin
                    seq_state_next = SEQ_SEND;
                    gap_cnt_next   = '0;
                    tx_state_next  = TX_START;
                    baud_cnt_next  = '0;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 1'b1;
                end
            end
            TX_START: begin
                if (baud_cnt_reg == BAUD_LAST) begin
                    baud_cnt_next = '0;
                    bit_idx_next  = '0;
                    tx_state_next = TX_DATA;
                end else begin
                    baud_cnt_next = baud_cnt_reg + 1'b1;
                end
            end
            TX_DATA: begin
                if (baud_cnt_reg == BAUD_LAST) begin
                    baud_cnt_next = '0;
                    if (bit_idx_reg == 3'd7) begin
                        tx_state_next = TX_STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg + 1'b1;
                end
            end
            TX_STOP: begin
                if (baud_cnt_reg == BAUD_LAST) begin
                    baud_cnt_next = '0;
                    if (byte_idx_reg == LAST_BYTE) begin
                        tx_state_next  = TX_IDLE;
                        seq_state_next = SEQ_GAP;
                        byte_idx_next  = '0;
                        gap_cnt_next   = '0;
                        led_next       = ~led_reg;
                    end else begin
                        // Next byte follows immediately, no idle between frames.
                        byte_idx_next = byte_idx_reg + 1'b1;
                        tx_state_next = TX_START;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg + 1'b1;
                end
            end
            default: begin
                tx_state_next = TX_IDLE;
            end
        endcase
    end

    // Line level and idle flag are derived from the next state so that the
    // registered outputs change on the same edge as the state itself.
    always_comb begin
        tx_next   = 1'b1;
        idle_next = (tx_state_next == TX_IDLE);
        case (tx_state_next)
            TX_START: tx_next = 1'b0;
            TX_DATA:  tx_next = rom[byte_idx_next][bit_idx_next];
            default:  tx_next = 1'b1;
        endcase
    end

    assign led  = led_reg;
    assign idle = idle_reg;
    assign tx   = tx_reg;

endmodule

// File: tb/tb_uart_tx_demo_unit.sv
// Testbench for uart_tx_demo_unit. Two instances: one at the default bit
// rate with a 1000-cycle gap, one at 4 clocks per bit with a 1-cycle gap.
// Outputs are sampled 1 time unit after each rising clock edge; positions
// are tracked by counting edges from each start-bit edge.
module tb_uart_tx_demo_unit;

    localparam logic [7:0] EXP_MSG [0:6] = '{8'h48, 8'h45, 8'h4C, 8'h4C,
                                             8'h4F, 8'h0D, 8'h0A};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic led_a, idle_a, tx_a;
    logic led_b, idle_b, tx_b;

    logic sel = 1'b0;
    int   cpb = 139;
    logic tx_m, idle_m, led_m;

    assign tx_m   = sel ? tx_b   : tx_a;
    assign idle_m = sel ? idle_b : idle_a;
    assign led_m  = sel ? led_b  : led_a;

    int check_cnt = 0;
    int err_cnt   = 0;

    uart_tx_demo_unit #(.CLKS_PER_BIT(139), .GAP_CYCLES(1000)) dut_a (
        .clk   (clk),
        .rst_n (rst_a),
        .led   (led_a),
        .idle  (idle_a),
        .tx    (tx_a)
    );

    uart_tx_demo_unit #(.CLKS_PER_BIT(4), .GAP_CYCLES(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_b),
        .led   (led_b),
        .idle  (idle_b),
        .tx    (tx_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Entered just after a start-bit edge; returns at the last cycle of the
    // stop bit (10*cpb - 1 edges after the start edge).
    task automatic recv_frame(output logic [7:0] b);
        logic [7:0] d;
        d = '0;
        tick(cpb / 2);
        chk("start_bit", tx_m, 1'b0);
        chk("idle_in_frame", idle_m, 1'b0);
        for (int k = 0; k < 8; k++) begin
            tick(cpb);
            d[k] = tx_m;
        end
        tick(cpb);
        chk("stop_bit", tx_m, 1'b1);
        tick(cpb - cpb / 2 - 1);
        chk("stop_end_tx", tx_m, 1'b1);
        chk("stop_end_idle", idle_m, 1'b0);
        b = d;
    endtask

    task automatic recv_msg(input int m, input logic led_exp);
        logic [7:0] b;
        for (int i = 0; i < 7; i++) begin
            recv_frame(b);
            $display("msg %0d byte %0d rx=%02h", m, i, b);
            chk($sformatf("byte_m%0d_%0d", m, i), b, EXP_MSG[i]);
            if (i == 0) chk("led_during_msg", led_m, !led_exp);
            tick(1);
            if (i < 6) begin
                chk("next_start_tx", tx_m, 1'b0);
                chk("next_start_idle", idle_m, 1'b0);
            end else begin
                chk("end_idle", idle_m, 1'b1);
                chk("end_tx", tx_m, 1'b1);
                chk("end_led", led_m, led_exp);
            end
        end
    endtask

    // Entered just after idle rose; checks the line stays quiet for the gap
    // and the next start bit begins exactly g edges later.
    task automatic gap_wait(input int g);
        tick(g - 1);
        chk("gap_tx", tx_m, 1'b1);
        chk("gap_idle", idle_m, 1'b1);
        tick(1);
        chk("gap_start_tx", tx_m, 1'b0);
        chk("gap_start_idle", idle_m, 1'b0);
    endtask

    initial begin
        logic [7:0] b;

        // Reset held: outputs at their reset values on every cycle.
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("rst_tx", tx_a, 1'b1);
            chk("rst_idle", idle_a, 1'b1);
            chk("rst_led", led_a, 1'b0);
        end
        rst_a = 1'b0;
        tick(1);
        chk("first_start_tx", tx_m, 1'b0);
        chk("first_start_idle", idle_m, 1'b0);

        recv_msg(1, 1'b1);
        gap_wait(1000);
        recv_msg(2, 1'b0);
        gap_wait(1000);
        recv_msg(3, 1'b1);
        gap_wait(1000);

        // Two full frames, then reset during data bit 0 of 'L' (a 0 bit).
        for (int i = 0; i < 2; i++) begin
            recv_frame(b);
            chk("pre_reset_byte", b, EXP_MSG[i]);
            tick(1);
        end
        tick(cpb / 2 + cpb);
        chk("pre_reset_tx", tx_m, 1'b0);
        chk("pre_reset_led", led_m, 1'b1);
        rst_a = 1'b1;
        #1;
        chk("async_rst_tx", tx_m, 1'b1);
        chk("async_rst_idle", idle_m, 1'b1);
        chk("async_rst_led", led_m, 1'b0);
        tick(3);
        rst_a = 1'b0;
        tick(1);
        chk("restart_tx", tx_m, 1'b0);
        recv_frame(b);
        $display("after reset byte rx=%02h", b);
        chk("restart_byte", b, 8'h48);

        // Fast instance: three back-to-back periods of 70*4+1 cycles.
        sel = 1'b1;
        cpb = 4;
        tick(3);
        rst_b = 1'b0;
        tick(1);
        chk("b_first_start_tx", tx_m, 1'b0);
        for (int m = 0; m < 3; m++) begin
            recv_msg(10 + m, (m % 2 == 0) ? 1'b1 : 1'b0);
            gap_wait(1);
        end

        $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
        $finish;
    end

endmodule
